// File: rtl/mgmt_pll_reconfig_seq.sv
// LTPI link PLL reconfiguration sequencer: holds the PLL in reset, writes the N/M/C0
// divider words over the reconfiguration port, then waits for lock with timeout and retry.
//
// state     | meaning
// IDLE      | waiting for a request; tracks lock loss for change_freq_st
// PLL_RST   | pll_reset held, timing the pre-write reset window
// WR_N      | write pre-divider word
// WR_M      | write feedback divider word
// WR_C0     | write latched C0 output-divider word
// WR_START  | kick the reconfiguration engine
// WAIT_LOCK | PLL released, lock timer running
// DONE      | locked; done reported while the request is held
// RETRY     | lock timed out; decide between another attempt and FAIL
// FAIL      | retries exhausted; PLL held in reset until the request drops

module mgmt_pll_reconfig_seq #(
  parameter logic [16*18-1:0] C0_TABLE     = {16{18'h00404}},
  parameter logic [17:0]      M_DIV        = 18'h00808,
  parameter logic [17:0]      N_DIV        = 18'h10000,
  parameter int unsigned      RST_CYCLES   = 16,
  parameter int unsigned      LOCK_TIMEOUT = 60000,
  parameter int unsigned      MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pll_reconfig,
  input  logic        reconfig_to_operational,
  input  logic [3:0]  operational_speed,
  output logic        pll_configuration_done,
  output logic        change_freq_st,
  output logic        reconfig_err,
  output logic        pll_reset,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  output logic [1:0]  retry_cnt
);

  localparam int unsigned TMR_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] RST_LOAD  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE, PLL_RST, WR_N, WR_M, WR_C0, WR_START, WAIT_LOCK, DONE, RETRY, FAIL
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic             wr_done;
  logic [17:0]      c0_word;
  logic             op_lat;
  logic [1:0]       lock_ff;
  logic             lock_sync;
  logic [3:0]       c0_idx;
  logic [8:0]       c0_lsb;
  logic [17:0]      c0_sel;

  // Entry 0 sits in the least-significant 18 bits of C0_TABLE.
  assign c0_idx    = reconfig_to_operational ? operational_speed : 4'd0;
  assign c0_lsb    = 9'(c0_idx) * 9'd18;
  assign c0_sel    = C0_TABLE[c0_lsb +: 18];
  assign lock_sync = lock_ff[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_ff <= 2'b00;
    else       lock_ff <= {lock_ff[0], pll_locked};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      tmr                    <= '0;
      wr_done                <= 1'b0;
      c0_word                <= '0;
      op_lat                 <= 1'b0;
      retry_cnt              <= 2'd0;
      reconfig_err           <= 1'b0;
      pll_configuration_done <= 1'b0;
      change_freq_st         <= 1'b0;
      pll_reset              <= 1'b1;
      mgmt_address           <= 6'd0;
      mgmt_writedata         <= 32'd0;
      mgmt_write             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pll_configuration_done <= 1'b0;
          if (!lock_sync) change_freq_st <= 1'b0;
          if (pll_reconfig) begin
            c0_word      <= c0_sel;
            op_lat       <= reconfig_to_operational;
            retry_cnt    <= 2'd0;
            reconfig_err <= 1'b0;
            if (!reconfig_to_operational) change_freq_st <= 1'b0;
            pll_reset    <= 1'b1;
            tmr          <= RST_LOAD;
            state        <= PLL_RST;
          end
        end

        PLL_RST: begin
          if (tmr == '0) begin
            mgmt_address   <= 6'h03;
            mgmt_writedata <= {14'd0, N_DIV};
            state          <= WR_N;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        // Each write: entry cycle, strobe until accepted, one idle cycle, advance.
        WR_N, WR_M, WR_C0, WR_START: begin
          if (wr_done) begin
            wr_done <= 1'b0;
            case (state)
              WR_N: begin
                mgmt_address   <= 6'h04;
                mgmt_writedata <= {14'd0, M_DIV};
                state          <= WR_M;
              end
              WR_M: begin
                mgmt_address   <= 6'h05;
                mgmt_writedata <= {14'd0, c0_word};
                state          <= WR_C0;
              end
              WR_C0: begin
                mgmt_address   <= 6'h02;
                mgmt_writedata <= 32'h0000_0001;
                state          <= WR_START;
              end
              default: begin
                pll_reset <= 1'b0;
                tmr       <= LOCK_LOAD;
                state     <= WAIT_LOCK;
              end
            endcase
          end else if (!mgmt_write) begin
            mgmt_write <= 1'b1;
          end else if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            wr_done    <= 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (lock_sync) begin
            change_freq_st <= op_lat;
            state          <= DONE;
          end else if (tmr == '0) begin
            pll_reset <= 1'b1;
            state     <= RETRY;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        RETRY: begin
          if (retry_cnt < RETRY_LIM) begin
            retry_cnt <= retry_cnt + 2'd1;
            tmr       <= RST_LOAD;
            state     <= PLL_RST;
          end else begin
            reconfig_err   <= 1'b1;
            change_freq_st <= 1'b0;
            state          <= FAIL;
          end
        end

        DONE: begin
          if (!lock_sync) change_freq_st <= 1'b0;
          if (pll_reconfig) begin
            pll_configuration_done <= 1'b1;
          end else begin
            pll_configuration_done <= 1'b0;
            state                  <= IDLE;
          end
        end

        FAIL: begin
          if (!pll_reconfig) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_pll_reconfig_seq.sv
// Directed bench for mgmt_pll_reconfig_seq: a write scoreboard plus an outcome model
// (attempts, retry count, error, done) derived from the lock behaviour of each scenario.
`timescale 1ns/1ps
module tb_mgmt_pll_reconfig_seq;

  localparam int LOCK_TO = 200;
  localparam int MAXR    = 3;

  function automatic logic [17:0] c0_of(input int i);
    logic [7:0] b;
    b = 8'(i + 1);
    return {2'b10, b, b};
  endfunction

  function automatic logic [287:0] build_tbl();
    logic [287:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[i*18 +: 18] = c0_of(i);
    return t;
  endfunction

  localparam logic [287:0] C0_TBL = build_tbl();

  function automatic logic [31:0] exp_c0(input bit op, input logic [3:0] spd);
    return {14'd0, c0_of(op ? int'(spd) : 0)};
  endfunction

  logic        clk, reset;
  logic        pll_reconfig, reconfig_to_operational;
  logic [3:0]  operational_speed;
  logic        pll_configuration_done, change_freq_st, reconfig_err, pll_reset;
  logic        pll_locked;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write, mgmt_waitrequest;
  logic [1:0]  retry_cnt;

  mgmt_pll_reconfig_seq #(
    .C0_TABLE(C0_TBL), .M_DIV(18'h00808), .N_DIV(18'h10000),
    .RST_CYCLES(16), .LOCK_TIMEOUT(LOCK_TO), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .pll_reconfig(pll_reconfig),
    .reconfig_to_operational(reconfig_to_operational), .operational_speed(operational_speed),
    .pll_configuration_done(pll_configuration_done), .change_freq_st(change_freq_st),
    .reconfig_err(reconfig_err), .pll_reset(pll_reset), .pll_locked(pll_locked),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata), .mgmt_write(mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest), .retry_cnt(retry_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0]  exp_a [0:63];
  logic [31:0] exp_d [0:63];
  int exp_n = 0;
  int rd = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  logic [31:0] last_c0 = 32'd0;

  int stall_n = 0;
  int lock_attempt = 0;
  int lock_delay = 0;
  int attempt = 0;
  int attempt_base = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic push_attempts(input logic [31:0] c0, input int k);
    for (int i = 0; i < k; i++) begin
      exp_a[exp_n] = 6'h03; exp_d[exp_n] = 32'h0001_0000; exp_n++;
      exp_a[exp_n] = 6'h04; exp_d[exp_n] = 32'h0000_0808; exp_n++;
      exp_a[exp_n] = 6'h05; exp_d[exp_n] = c0;            exp_n++;
      exp_a[exp_n] = 6'h02; exp_d[exp_n] = 32'h0000_0001; exp_n++;
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reconfiguration slave: stalls each write for stall_n cycles.
  initial begin
    int scnt;
    scnt = 0;
    mgmt_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_n == 0) mgmt_waitrequest = 1'b0;
      else if (mgmt_write) begin
        if (scnt < stall_n) begin mgmt_waitrequest = 1'b1; scnt++; end
        else mgmt_waitrequest = 1'b0;
      end else begin
        mgmt_waitrequest = 1'b1;
        scnt = 0;
      end
    end
  end

  // PLL model: lock lock_delay cycles after release, from attempt lock_attempt on.
  initial begin
    int lcnt;
    bit prev_rst;
    lcnt = 0;
    prev_rst = 1'b1;
    pll_locked = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (pll_reset) begin
        pll_locked = 1'b0;
        lcnt = 0;
      end else begin
        if (prev_rst) attempt++;
        lcnt++;
        if (lock_attempt == 0) pll_locked = 1'b0;
        else if ((attempt - attempt_base) >= lock_attempt && lcnt >= lock_delay) pll_locked = 1'b1;
      end
      prev_rst = pll_reset;
    end
  end

  // Per-cycle compare against the write scoreboard and output rules.
  initial begin
    bit prev_stall, prev_req;
    logic [5:0]  ha;
    logic [31:0] hd;
    prev_stall = 1'b0;
    prev_req = 1'b0;
    ha = '0;
    hd = '0;
    forever begin
      @(negedge clk);
      if (reset) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          check_eq("stall_hold_wr", 32'(mgmt_write), 32'd1);
          check_eq("stall_hold_addr", 32'(mgmt_address), 32'(ha));
          check_eq("stall_hold_data", mgmt_writedata, hd);
        end
        if (mgmt_write) check_eq("wr_in_pll_reset", 32'(pll_reset), 32'd1);
        if (mgmt_write && mgmt_waitrequest) begin
          prev_stall = 1'b1;
          ha = mgmt_address;
          hd = mgmt_writedata;
          stall_cnt++;
        end else prev_stall = 1'b0;
        if (mgmt_write && !mgmt_waitrequest) begin
          check_eq("wr_expected", 32'(rd < exp_n), 32'd1);
          if (rd < exp_n) begin
            check_eq("wr_addr", 32'(mgmt_address), 32'(exp_a[rd]));
            check_eq("wr_data", mgmt_writedata, exp_d[rd]);
            rd++;
          end
          if (mgmt_address == 6'h05) last_c0 = mgmt_writedata;
        end
        if (pll_configuration_done) begin
          done_cnt++;
          check_eq("done_needs_req", 32'(prev_req), 32'd1);
          check_eq("done_excl_err", 32'(reconfig_err), 32'd0);
        end
      end
      prev_req = pll_reconfig;
    end
  end

  task automatic run_seq(input bit op, input logic [3:0] spd, input int stall,
                         input int lock_at, input int ldelay, input logic [31:0] c0_lit);
    int att, n, m, lk, bound, d0, s0;
    bit exp_ok;
    exp_ok = (lock_at >= 1 && lock_at <= MAXR + 1);
    att = exp_ok ? lock_at : MAXR + 1;
    stall_n = stall;
    lock_attempt = lock_at;
    lock_delay = ldelay;
    attempt_base = attempt;
    push_attempts(exp_c0(op, spd), att);
    d0 = done_cnt;
    s0 = stall_cnt;
    reconfig_to_operational = op;
    operational_speed = spd;
    pll_reconfig = 1'b1;
    n = 0;
    while (!mgmt_write && n < 100) begin
      tick();
      n++;
      if (n == 1) begin
        check_eq("err_clr_on_accept", 32'(reconfig_err), 32'd0);
        check_eq("retry_clr_on_accept", 32'(retry_cnt), 32'd0);
        operational_speed = spd + 4'd3;
      end
    end
    check_eq("first_wr_latency", n, 18);
    if (stall == 0) begin
      while (pll_reset && n < 200) begin tick(); n++; end
      check_eq("reset_release_cycle", n, 29);
    end
    bound = att * (LOCK_TO + 40 + 8 * stall) + 100;
    m = 0;
    lk = -1;
    while (m < bound) begin
      tick();
      m++;
      if (pll_locked && lk < 0) lk = m;
      if (exp_ok ? pll_configuration_done : reconfig_err) break;
    end
    check_eq("outcome_in_time", 32'(m < bound), 32'd1);
    if (exp_ok) check_eq("lock_to_done_3_4", 32'(lk >= 0 && m - lk >= 3 && m - lk <= 4), 32'd1);
    check_eq("done", 32'(pll_configuration_done), 32'(exp_ok));
    check_eq("reconfig_err", 32'(reconfig_err), 32'(!exp_ok));
    check_eq("retry_cnt", 32'(retry_cnt), 32'(att - 1));
    check_eq("change_freq_st", 32'(change_freq_st), 32'(exp_ok && op));
    check_eq("pll_reset", 32'(pll_reset), 32'(!exp_ok));
    check_eq("attempts", attempt - attempt_base, att);
    check_eq("writes_all_seen", rd, exp_n);
    check_eq("stall_cycles", stall_cnt - s0, 4 * stall * att);
    check_eq("c0_word_literal", last_c0, c0_lit);
    if (!exp_ok) check_eq("no_done_on_fail", done_cnt - d0, 0);
    pll_reconfig = 1'b0;
    tick();
    check_eq("done_fall", 32'(pll_configuration_done), 32'd0);
    check_eq("err_sticky", 32'(reconfig_err), 32'(!exp_ok));
  endtask

  initial begin
    int n, d0;
    reset = 1'b1;
    pll_reconfig = 1'b0;
    reconfig_to_operational = 1'b0;
    operational_speed = 4'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("rst_pll_reset", 32'(pll_reset), 32'd1);
    check_eq("rst_outputs", {26'd0, pll_configuration_done, change_freq_st, reconfig_err,
                             mgmt_write, retry_cnt}, 32'd0);
    check_eq("rst_addr", 32'(mgmt_address), 32'd0);
    check_eq("rst_data", mgmt_writedata, 32'd0);

    // Base-frequency request.
    run_seq(1'b0, 4'd0, 0, 1, 50, 32'h0002_0101);

    // Operational speed 4 with 5-cycle stalls, then lock loss while idle.
    run_seq(1'b1, 4'd4, 5, 1, 50, 32'h0002_0505);
    check_eq("change_held_idle", 32'(change_freq_st), 32'd1);
    lock_attempt = 0;
    repeat (6) tick();
    check_eq("change_clr_on_unlock", 32'(change_freq_st), 32'd0);

    // Lock never arrives.
    run_seq(1'b0, 4'd0, 0, 0, 0, 32'h0002_0101);

    // Lock on the second attempt.
    run_seq(1'b0, 4'd0, 0, 2, 50, 32'h0002_0101);

    // Request dropped during WR_M.
    stall_n = 0;
    lock_attempt = 1;
    lock_delay = 10;
    attempt_base = attempt;
    push_attempts(exp_c0(1'b1, 4'd2), 1);
    d0 = done_cnt;
    reconfig_to_operational = 1'b1;
    operational_speed = 4'd2;
    pll_reconfig = 1'b1;
    n = 0;
    while (mgmt_address != 6'h04 && n < 100) begin tick(); n++; end
    check_eq("reach_wr_m", 32'(n < 100), 32'd1);
    pll_reconfig = 1'b0;
    repeat (200) tick();
    check_eq("drop_burst_done", rd, exp_n);
    check_eq("drop_no_done", done_cnt - d0, 0);
    check_eq("drop_pll_running", 32'(pll_reset), 32'd0);
    check_eq("drop_c0_literal", last_c0, 32'h0002_0303);

    // Reset during the second WAIT_LOCK.
    stall_n = 0;
    lock_attempt = 0;
    attempt_base = attempt;
    push_attempts(exp_c0(1'b0, 4'd0), 2);
    reconfig_to_operational = 1'b0;
    pll_reconfig = 1'b1;
    n = 0;
    while (!(retry_cnt == 2'd1 && !pll_reset) && n < 1000) begin tick(); n++; end
    check_eq("reach_wait_lock_2", 32'(n < 1000), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_pll_reset", 32'(pll_reset), 32'd1);
    check_eq("mid_rst_outputs", {26'd0, pll_configuration_done, change_freq_st, reconfig_err,
                                 mgmt_write, retry_cnt}, 32'd0);
    check_eq("mid_rst_addr", 32'(mgmt_address), 32'd0);
    check_eq("mid_rst_data", mgmt_writedata, 32'd0);
    check_eq("mid_rst_writes", rd, exp_n);
    pll_reconfig = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    run_seq(1'b0, 4'd0, 0, 1, 20, 32'h0002_0101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
